// File: rtl/reg_file_sb.sv
// reg_file_sb
//   Two-read / one-write register file with a busy (scoreboard) bit per
//   register. Reads are registered with one cycle of latency. A write and a
//   read of the same register in the same cycle return the new data. The busy
//   outputs show the busy state after that edge's write and reserve.
//
// Parameters
//   DATA_W   register width
//   ADDR_W   address width, depth = 2**ADDR_W
//   ZERO_REG 1: register 0 is hardwired to zero and is never busy
//
// Ports
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   wr_en     write strobe
//   wr_addr   write address
//   wr_data   write data
//   rsv_en    reserve strobe (sets busy of rsv_addr)
//   rsv_addr  register to reserve
//   rs1, rs2  read addresses
//   rs_out    registered read data, port 1
//   rt_out    registered read data, port 2
//   rs_busy   registered busy bit of rs1
//   rt_busy   registered busy bit of rs2
module reg_file_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 6,
    parameter int ZERO_REG = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    input  logic [ADDR_W-1:0] rs1,
    input  logic [ADDR_W-1:0] rs2,
    output logic [DATA_W-1:0] rs_out,
    output logic [DATA_W-1:0] rt_out,
    output logic              rs_busy,
    output logic              rt_busy
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  busy_nxt;
    logic              wr_ok;
    logic              rsv_ok;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;

    // With a hardwired zero register, accesses to address 0 are dropped here.
    // Register 0 then never changes from its reset value, so reads and bypass
    // of address 0 need no extra handling.
    assign wr_ok  = wr_en  && !((ZERO_REG != 0) && (wr_addr  == '0));
    assign rsv_ok = rsv_en && !((ZERO_REG != 0) && (rsv_addr == '0));

    // Apply the reserve after the write, so a reserve wins when both target
    // the same register. The reserve belongs to the newer instruction.
    always_comb begin
        busy_nxt = busy;
        if (wr_ok)
            busy_nxt[wr_addr] = 1'b0;
        if (rsv_ok)
            busy_nxt[rsv_addr] = 1'b1;
    end

    always_comb begin
        rs_data = regs[rs1];
        rt_data = regs[rs2];
        if (wr_ok && (wr_addr == rs1))
            rs_data = wr_data;
        if (wr_ok && (wr_addr == rs2))
            rt_data = wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                regs[i] <= '0;
            busy    <= '0;
            rs_out  <= '0;
            rt_out  <= '0;
            rs_busy <= 1'b0;
            rt_busy <= 1'b0;
        end else begin
            if (wr_ok)
                regs[wr_addr] <= wr_data;
            busy    <= busy_nxt;
            rs_out  <= rs_data;
            rt_out  <= rt_data;
            rs_busy <= busy_nxt[rs1];
            rt_busy <= busy_nxt[rs2];
        end
    end

endmodule

// File: tb/tb_reg_file_sb.sv
// Testbench for reg_file_sb. Two instances share the same stimulus: one with
// ZERO_REG=0 and one with ZERO_REG=1. The driver pushes expected outputs into
// a queue. A separate monitor pops them once the capturing edge has passed.
module tb_reg_file_sb;

    localparam int DW = 32;
    localparam int AW = 6;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_en, rsv_en;
    logic [AW-1:0] wr_addr, rsv_addr, rs1, rs2;
    logic [DW-1:0] wr_data;

    logic [DW-1:0] rs_out0, rt_out0, rs_out1, rt_out1;
    logic          rs_busy0, rt_busy0, rs_busy1, rt_busy1;

    always #5 clk = ~clk;

    reg_file_sb #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .rs1(rs1), .rs2(rs2),
        .rs_out(rs_out0), .rt_out(rt_out0),
        .rs_busy(rs_busy0), .rt_busy(rt_busy0)
    );

    reg_file_sb #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .rs1(rs1), .rs2(rs2),
        .rs_out(rs_out1), .rt_out(rt_out1),
        .rs_busy(rs_busy1), .rt_busy(rt_busy1)
    );

    typedef struct {
        int                 due;
        logic [1:0][DW-1:0] rs;
        logic [1:0][DW-1:0] rt;
        logic [1:0]         rsb;
        logic [1:0]         rtb;
    } exp_t;

    exp_t          sbq[$];
    int            cycle = 0;
    int            checks = 0;
    int            errors = 0;

    // Reference state. Index 0 models ZERO_REG=0 and index 1 models ZERO_REG=1.
    logic [DW-1:0] m_reg  [2][DEPTH];
    logic          m_busy [2][DEPTH];

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    task automatic model_clear();
        for (int z = 0; z < 2; z++)
            for (int i = 0; i < DEPTH; i++) begin
                m_reg[z][i]  = '0;
                m_busy[z][i] = 1'b0;
            end
    endtask

    task automatic idle_inputs();
        wr_en = 0; wr_addr = '0; wr_data = '0;
        rsv_en = 0; rsv_addr = '0; rs1 = '0; rs2 = '0;
    endtask

    // Present one cycle of stimulus. The register file state after the next
    // edge is the model state after the write and then the reserve are
    // applied. The read ports return that post-edge state. This gives the
    // bypass and the reserve-wins behaviour without modelling them separately.
    task automatic step(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                        input logic re, input logic [AW-1:0] ra,
                        input logic [AW-1:0] a1, input logic [AW-1:0] a2);
        exp_t e;
        @(posedge clk);
        #1;
        wr_en = we; wr_addr = wa; wr_data = wd;
        rsv_en = re; rsv_addr = ra; rs1 = a1; rs2 = a2;
        for (int z = 0; z < 2; z++) begin
            if (we && !(z == 1 && wa == 0)) begin
                m_reg[z][wa]  = wd;
                m_busy[z][wa] = 1'b0;
            end
            if (re && !(z == 1 && ra == 0))
                m_busy[z][ra] = 1'b1;
            e.rs[z]  = (z == 1 && a1 == 0) ? '0 : m_reg[z][a1];
            e.rt[z]  = (z == 1 && a2 == 0) ? '0 : m_reg[z][a2];
            e.rsb[z] = (z == 1 && a1 == 0) ? 1'b0 : m_busy[z][a1];
            e.rtb[z] = (z == 1 && a2 == 0) ? 1'b0 : m_busy[z][a2];
        end
        e.due = cycle + 1;
        sbq.push_back(e);
    endtask

    task automatic check_zero(input string tag);
        check({tag, " rs_out0"}, rs_out0, '0);
        check({tag, " rt_out0"}, rt_out0, '0);
        check({tag, " rs_busy0"}, {31'b0, rs_busy0}, '0);
        check({tag, " rt_busy0"}, {31'b0, rt_busy0}, '0);
        check({tag, " rs_out1"}, rs_out1, '0);
        check({tag, " rt_out1"}, rt_out1, '0);
        check({tag, " rs_busy1"}, {31'b0, rs_busy1}, '0);
        check({tag, " rt_busy1"}, {31'b0, rt_busy1}, '0);
    endtask

    // Assert reset asynchronously, between clock edges, in the middle of a run.
    task automatic do_reset();
        @(posedge clk);
        #3;
        rst_n = 0;
        idle_inputs();
        sbq.delete();
        model_clear();
        #1;
        check_zero("reset_immediate");
        @(posedge clk);
        #2;
        check_zero("reset_held");
        @(negedge clk);
        rst_n = 1;
    endtask

    // Monitor: compare each expectation at the first falling edge after the
    // edge that captured its stimulus.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (sbq.size() > 0 && sbq[0].due <= cycle) begin
                e = sbq.pop_front();
                check("rs_out z0", rs_out0, e.rs[0]);
                check("rt_out z0", rt_out0, e.rt[0]);
                check("rs_busy z0", {31'b0, rs_busy0}, {31'b0, e.rsb[0]});
                check("rt_busy z0", {31'b0, rt_busy0}, {31'b0, e.rtb[0]});
                check("rs_out z1", rs_out1, e.rs[1]);
                check("rt_out z1", rt_out1, e.rt[1]);
                check("rs_busy z1", {31'b0, rs_busy1}, {31'b0, e.rsb[1]});
                check("rt_busy z1", {31'b0, rt_busy1}, {31'b0, e.rtb[1]});
            end
        end
    end

    initial begin
        logic [AW-1:0] a [4];
        int            budget;
        rst_n = 0;
        idle_inputs();
        model_clear();
        #1;
        check_zero("power_on");
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1;

        // Write r7, then read it back.
        step(1, 7, 32'hDEADBEEF, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 7, 7);
        // Write r3 and read it on both ports in the same cycle (bypass).
        step(1, 3, 32'h6, 0, 0, 3, 3);
        // Reserve r10, read it busy, then write it to clear busy.
        step(0, 0, 0, 1, 10, 0, 0);
        step(0, 0, 0, 0, 0, 10, 10);
        step(1, 10, 32'h55, 0, 0, 10, 10);
        // Write and reserve r12 on the same edge: the reserve wins.
        step(1, 12, 32'h99, 1, 12, 12, 12);
        step(0, 0, 0, 0, 0, 12, 3);
        // Write and reserve r0: the ZERO_REG=1 instance drops both.
        step(1, 0, 32'hFFFFFFFF, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 7);
        // Write and reserve different registers on the same edge.
        step(1, 20, 32'h1234, 1, 21, 20, 21);

        do_reset();
        step(0, 0, 0, 0, 0, 5, 7);
        step(0, 0, 0, 0, 0, 5, 12);

        // Random stimulus. Addresses are biased toward a few low registers so
        // that collisions, bypasses and address 0 occur often.
        for (int n = 0; n < 3000; n++) begin
            for (int k = 0; k < 4; k++)
                a[k] = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, DEPTH - 1))
                                                   : AW'($urandom_range(0, 7));
            step(1'($urandom_range(0, 1)), a[0], $urandom,
                 1'($urandom_range(0, 2) == 0), a[1], a[2], a[3]);
            if (n == 1500)
                do_reset();
        end

        step(0, 0, 0, 0, 0, 0, 0);
        budget = 20;
        while (sbq.size() > 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        @(negedge clk);
        #1;
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", sbq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
